gpio_debounce: RTL

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

---
 rtl/gpio_debounce_pkg.sv | 15 +
 rtl/debounce_bit.sv | 42 ++++
 rtl/gpio_debounce.sv | 72 +++++++
 3 files changed

// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: register map, reset values and threshold helper for gpio_debounce
package gpio_debounce_pkg;
  typedef enum logic [1:0] {
    PERIOD_REG    = 2'd0,
    THRESHOLD_REG = 2'd1,
    DB_ENABLE_REG = 2'd2,
    CHANGED_REG   = 2'd3
  } reg_addr_e;
  localparam int THR_W = 4;
  localparam int unsigned PERIOD_RST = 999;
  localparam logic [THR_W-1:0] THRESHOLD_RST = 4'd4;
  function automatic logic [THR_W-1:0] eff_threshold(input logic [THR_W-1:0] t);
    return (t == '0) ? THR_W'(1) : t;
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, stability counter and clean output flop for one GPIO bit
module debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin,
  input  logic             tick,
  input  logic             en,
  input  logic [THR_W-1:0] threshold,
  output logic             data_out,
  output logic             change
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [THR_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic data_q, data_d, sync_out, hit;
  // next state: shift synchronizer, count mismatching ticks, flip clean level at threshold
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    sync_out = sync_q[SYNC_STAGES-1];
    cnt_inc = cnt_q + THR_W'(1);
    hit = tick && (cnt_inc == threshold);
    data_d = (!en || (sync_out != data_q && hit)) ? sync_out : data_q;
    cnt_d = (!en || sync_out == data_q || hit) ? '0 : tick ? cnt_inc : cnt_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      data_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
  assign data_out = data_q;
  assign change = data_d != data_q;
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: 32-bit GPIO input synchronizer/debouncer with Avalon-MM control registers
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] pin_in,
  output logic [31:0] data_out
);
  logic [PRESCALE_WIDTH-1:0] period_q, period_d, pre_q, pre_d;
  logic [THR_W-1:0] thr_q, thr_d, thr_eff;
  logic [31:0] en_q, en_d, chg_q, chg_d, change;
  logic wr, wr_period, tick, unused_byteenable;
  assign unused_byteenable = ^byteenable;
  // register writes, prescaler and sticky change flags (set beats clear)
  always_comb begin
    wr = chipselect && write;
    wr_period = wr && (address == PERIOD_REG);
    tick = pre_q == period_q;
    pre_d = (wr_period || tick) ? '0 : pre_q + PRESCALE_WIDTH'(1);
    period_d = wr_period ? writedata[PRESCALE_WIDTH-1:0] : period_q;
    thr_d = (wr && address == THRESHOLD_REG) ? writedata[THR_W-1:0] : thr_q;
    en_d = (wr && address == DB_ENABLE_REG) ? writedata : en_q;
    chg_d = (chg_q & ~((wr && address == CHANGED_REG) ? writedata : 32'h0)) | change;
    thr_eff = eff_threshold(thr_q);
  end
  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= PRESCALE_WIDTH'(PERIOD_RST);
      pre_q    <= '0;
      thr_q    <= THRESHOLD_RST;
      en_q     <= '0;
      chg_q    <= '0;
    end else begin
      period_q <= period_d;
      pre_q    <= pre_d;
      thr_q    <= thr_d;
      en_q     <= en_d;
      chg_q    <= chg_d;
    end
  end
  // combinational read mux
  always_comb begin
    readdata = !(chipselect && read) ? 32'h0 :
               (address == PERIOD_REG)    ? 32'(period_q) :
               (address == THRESHOLD_REG) ? 32'(thr_q) :
               (address == DB_ENABLE_REG) ? en_q : chg_q;
  end
  for (genvar i = 0; i < 32; i++) begin : g_bit
    debounce_bit #(.SYNC_STAGES(SYNC_STAGES)) u_bit (
      .clk      (clk),
      .reset    (reset),
      .pin      (pin_in[i]),
      .tick     (tick),
      .en       (en_q[i]),
      .threshold(thr_eff),
      .data_out (data_out[i]),
      .change   (change[i])
    );
  end
endmodule
